// File: rtl/axi_lite_ctrl_pkg.sv
// Shared constants for the AD9643 capture-path AXI4-Lite control register bank.
// Word index constants are the byte offset divided by four (address bits [4:2]).
package axi_lite_ctrl_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;  // 0x00
    localparam logic [2:0] REG_CH_EN    = 3'd1;  // 0x04
    localparam logic [2:0] REG_STATUS   = 3'd2;  // 0x08
    localparam logic [2:0] REG_IRQ_MASK = 3'd3;  // 0x0C
    localparam logic [2:0] REG_VERSION  = 3'd4;  // 0x10

    localparam int CTRL_GLOBAL_EN_BIT = 0;
    localparam int CTRL_DDR_RST_BIT   = 1;
    localparam int STATUS_BUSY_BIT    = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // IRQ_MASK only exists when the interrupt feature is built in.
    function automatic logic reg_mapped(input logic [2:0] idx, input logic irq_en);
        case (idx)
            REG_CTRL, REG_CH_EN, REG_STATUS, REG_VERSION: reg_mapped = 1'b1;
            REG_IRQ_MASK:                                 reg_mapped = irq_en;
            default:                                      reg_mapped = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_rst_pulse.sv
// Timed DDR interface reset: busy while the down-counter is nonzero.
// Reset preloads the count so the DDR logic starts held in reset.
module axi_lite_rst_pulse #(
    parameter int C_RST_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic busy
);

    localparam int CW = $clog2(C_RST_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(C_RST_CYCLES);

    logic [CW-1:0] count;

    // A trigger seen while the pulse is running is dropped, never extends it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end else if (trigger) begin
            count <= LOAD;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status registers for the AD9643 capture path.
// Define AXI_CTRL_IRQ_EN to build the IRQ_MASK register and the irq output.
module axi_lite_ctrl_regs
    import axi_lite_ctrl_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          C_NUM_CH           = 2,
    parameter int          C_RST_CYCLES       = 16,
    parameter logic [31:0] C_VERSION          = 32'h0002_0000
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [C_NUM_CH-1:0]             ch_ovf,
    output logic [C_NUM_CH-1:0]             data_en,
    output logic                            ddr_reset
`ifdef AXI_CTRL_IRQ_EN
    ,
    output logic                            irq
`endif
);

`ifdef AXI_CTRL_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    // valid/ready: a beat transfers on the rising edge where both are high; the
    // master holds valid and payload until then, the slave pulses ready one cycle.
    logic                wr_en, rd_en, aw_go, wr_ok, rd_ok;
    logic [2:0]          wr_idx, rd_idx;
    logic [C_NUM_CH-1:0] lane_mask, wr_bits, ch_en_mask, status_clr;
    logic [C_NUM_CH-1:0] ch_en, status;
    logic                global_en, rst_trigger, rst_busy;
    logic [31:0]         rd_word;
    logic                unused_ok;

    assign aw_go  = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
    assign wr_en  = s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready;
    assign rd_en  = s_axi_arvalid & s_axi_arready;
    assign wr_idx = s_axi_awaddr[4:2];
    assign rd_idx = s_axi_araddr[4:2];
    assign wr_ok  = reg_mapped(wr_idx, IRQ_EN);
    assign rd_ok  = reg_mapped(rd_idx, IRQ_EN);
    assign wr_bits = s_axi_wdata[C_NUM_CH-1:0];
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                         s_axi_wdata, s_axi_wstrb};

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < C_NUM_CH; i++) lane_mask[i] = s_axi_wstrb[i/8];
    end

    assign ch_en_mask  = (wr_en && wr_idx == REG_CH_EN) ? lane_mask : '0;
    assign status_clr  = (wr_en && wr_idx == REG_STATUS) ? (wr_bits & lane_mask) : '0;
    assign rst_trigger = wr_en && wr_idx == REG_CTRL && s_axi_wstrb[0]
                         && s_axi_wdata[CTRL_DDR_RST_BIT];

    axi_lite_rst_pulse #(.C_RST_CYCLES(C_RST_CYCLES)) u_rst_pulse (
        .clk    (s_axi_aclk),
        .rst    (s_axi_areset),
        .trigger(rst_trigger),
        .busy   (rst_busy)
    );

    assign ddr_reset = rst_busy;

`ifdef AXI_CTRL_IRQ_EN
    logic [C_NUM_CH-1:0] irq_mask;
    logic [C_NUM_CH-1:0] irq_mask_wr;

    assign irq_mask_wr = (wr_en && wr_idx == REG_IRQ_MASK) ? lane_mask : '0;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            irq_mask <= (irq_mask & ~irq_mask_wr) | (wr_bits & irq_mask_wr);
            irq      <= |(status & irq_mask);
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_CTRL: begin
                rd_word[CTRL_GLOBAL_EN_BIT] = global_en;
                rd_word[CTRL_DDR_RST_BIT]   = rst_busy;
            end
            REG_CH_EN: rd_word[C_NUM_CH-1:0] = ch_en;
            REG_STATUS: begin
                rd_word[C_NUM_CH-1:0]    = status;
                rd_word[STATUS_BUSY_BIT] = rst_busy;
            end
`ifdef AXI_CTRL_IRQ_EN
            REG_IRQ_MASK: rd_word[C_NUM_CH-1:0] = irq_mask;
`endif
            REG_VERSION: rd_word = C_VERSION;
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            global_en     <= 1'b0;
            ch_en         <= '0;
            status        <= '0;
            data_en       <= '0;
        end else begin
            s_axi_awready <= aw_go;
            s_axi_wready  <= aw_go;
            if (wr_en) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
                s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end

            if (wr_en && wr_idx == REG_CTRL && s_axi_wstrb[0])
                global_en <= s_axi_wdata[CTRL_GLOBAL_EN_BIT];
            ch_en   <= (ch_en & ~ch_en_mask) | (wr_bits & ch_en_mask);
            // New overflow events win over a simultaneous clear.
            status  <= (status & ~status_clr) | ch_ovf;
            data_en <= ch_en & {C_NUM_CH{global_en & ~rst_busy}};
        end
    end

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Self-checking bench for axi_lite_ctrl_regs against a transaction-level register model.
// Build with +define+AXI_CTRL_IRQ_EN to also cover IRQ_MASK and irq.
module tb_axi_lite_ctrl_regs;

  localparam int          NCH  = 2;
  localparam int          RSTC = 16;
  localparam logic [31:0] VER  = 32'h0002_0000;
`ifdef AXI_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk, rst;
  logic [4:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NCH-1:0] ch_ovf, data_en;
  logic ddr_reset;
  logic irq;

  axi_lite_ctrl_regs dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ch_ovf(ch_ovf), .data_en(data_en), .ddr_reset(ddr_reset)
`ifdef AXI_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

`ifndef AXI_CTRL_IRQ_EN
  assign irq = 1'b0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural register model, advanced on every clock edge
  int cyc = 0;
  int rst_end = RSTC;
  int aw_hs_cnt = 0;
  logic m_global = 1'b0;
  logic [NCH-1:0] m_chen = '0, m_status = '0, m_mask = '0, exp_den = '0;
  logic exp_irq = 1'b0;
  logic [33:0] exp_q[$];
  logic [1:0]  exp_b_q[$];

  function automatic logic mapped(input logic [2:0] idx);
    return idx == 3'd0 || idx == 3'd1 || idx == 3'd2 || idx == 3'd4 || (IRQ_ON && idx == 3'd3);
  endfunction

  function automatic logic [33:0] model_read(input logic [2:0] idx, input logic busy);
    logic [31:0] d;
    d = '0;
    if (!mapped(idx)) return {2'b10, 32'h0};
    case (idx)
      3'd0: begin d[0] = m_global; d[1] = busy; end
      3'd1: d[NCH-1:0] = m_chen;
      3'd2: begin d[NCH-1:0] = m_status; d[16] = busy; end
      3'd3: d[NCH-1:0] = m_mask;
      default: d = VER;
    endcase
    return {2'b00, d};
  endfunction

  always @(posedge clk) begin
    logic busy, trig;
    logic [2:0] idx;
    logic [NCH-1:0] clr;
    if (rst) begin
      cyc = 0; rst_end = RSTC; m_global = 1'b0;
      m_chen = '0; m_status = '0; m_mask = '0; exp_den = '0; exp_irq = 1'b0;
      exp_q.delete(); exp_b_q.delete();
    end else begin
      busy = (cyc < rst_end);
      exp_den = busy ? '0 : (m_chen & {NCH{m_global}});
      exp_irq = |(m_status & m_mask);
      if (arvalid && arready) exp_q.push_back(model_read(araddr[4:2], busy));
      clr = '0;
      trig = 1'b0;
      if (awvalid && awready && wvalid && wready) begin
        aw_hs_cnt++;
        idx = awaddr[4:2];
        exp_b_q.push_back(mapped(idx) ? 2'b00 : 2'b10);
        if (idx == 3'd0 && wstrb[0]) begin
          m_global = wdata[0];
          trig = wdata[1];
        end
        for (int i = 0; i < NCH; i++) begin
          if (wstrb[i/8]) begin
            if (idx == 3'd1) m_chen[i] = wdata[i];
            if (idx == 3'd2) clr[i] = wdata[i];
            if (idx == 3'd3 && IRQ_ON) m_mask[i] = wdata[i];
          end
        end
      end
      m_status = (m_status & ~clr) | ch_ovf;
      cyc++;
      if (trig && cyc > rst_end) rst_end = cyc + RSTC;
    end
  end

  // per-cycle compare of the sideband outputs
  always @(negedge clk) begin
    if (!rst) begin
      check("ddr_reset", 64'(ddr_reset), 64'(cyc < rst_end));
      check("data_en", 64'(data_en), 64'(exp_den));
      if (IRQ_ON) check("irq", 64'(irq), 64'(exp_irq));
    end
  end

  // driver tasks
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int b_delay);
    int n;
    int aw0;
    aw0 = aw_hs_cnt;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1;
    repeat (aw_lead) begin @(posedge clk); #1; end
    wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_ready_seen", 64'(awready), 64'(1));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_single_handshake", 64'(aw_hs_cnt - aw0), 64'(1));
    repeat (b_delay) begin
      check("bvalid_hold", 64'(bvalid), 64'(1));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    check("bvalid", 64'(bvalid), 64'(1));
    if (exp_b_q.size() > 0) check("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
    else check("bresp_expected", 64'(0), 64'(1));
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", 64'(bvalid), 64'(0));
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_delay,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic [33:0] e;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_ready_seen", 64'(arready), 64'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (r_delay) begin
      check("rvalid_hold", 64'(rvalid), 64'(1));
      @(posedge clk); #1;
    end
    rready = 1'b1;
    check("rvalid", 64'(rvalid), 64'(1));
    data = rdata; resp = rresp;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rdata", 64'(rdata), 64'(e[31:0]));
      check("rresp", 64'(rresp), 64'(e[33:32]));
    end else begin
      check("rdata_expected", 64'(0), 64'(1));
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int n;
    rst = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0; ch_ovf = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_resps", 64'({bresp, rresp}), 64'(0));
    check("rst_data_en", 64'(data_en), 64'(0));
    check("rst_ddr_reset", 64'(ddr_reset), 64'(1));
    check("rst_irq", 64'(irq), 64'(0));
    rst = 1'b0;
    n = 0;
    while (ddr_reset && n < 40) begin n++; @(negedge clk); end
    check("ddr_len_after_reset", 64'(n), 64'(16));
    #1;

    axi_read(5'h10, 0, d, r);
    check("version_literal", 64'({r, d}), 64'({2'b00, 32'h0002_0000}));

    axi_write(5'h04, 32'h3, 4'hf, 0, 0);
    axi_write(5'h00, 32'h1, 4'hf, 0, 0);
    check("data_en_on_literal", 64'(data_en), 64'(2'b11));
    axi_write(5'h04, 32'h0, 4'b1110, 0, 0);
    axi_read(5'h04, 0, d, r);
    check("ch_en_strb_literal", 64'(d), 64'(3));

    axi_write(5'h00, 32'h3, 4'hf, 0, 0);
    axi_read(5'h08, 1, d, r);
    check("status_busy_literal", 64'(d[16]), 64'(1));
    axi_write(5'h00, 32'h3, 4'hf, 0, 0);
    idle(25);
    axi_read(5'h08, 0, d, r);
    check("status_idle_literal", 64'(d), 64'(0));
    check("data_en_back_literal", 64'(data_en), 64'(2'b11));

    ch_ovf = 2'b10; idle(1); ch_ovf = '0;
    axi_read(5'h08, 0, d, r);
    check("ovf_sticky_literal", 64'(d), 64'(2));
    ch_ovf = 2'b10;
    axi_write(5'h08, 32'h2, 4'hf, 0, 0);
    ch_ovf = '0;
    axi_read(5'h08, 0, d, r);
    check("ovf_set_wins_literal", 64'(d), 64'(2));
    axi_write(5'h08, 32'h2, 4'hf, 0, 0);
    axi_read(5'h08, 0, d, r);
    check("ovf_cleared_literal", 64'(d), 64'(0));

    axi_write(5'h04, 32'h1, 4'hf, 5, 3);

    axi_read(5'h1c, 2, d, r);
    check("unmapped_read_literal", 64'({r, d}), 64'({2'b10, 32'h0}));
    axi_write(5'h14, 32'hffff_ffff, 4'hf, 0, 0);
    check("unmapped_write_resp_literal", 64'(bresp), 64'(2'b10));
    for (int a = 0; a < 5; a++) axi_read(5'(a * 4), 0, d, r);

`ifdef AXI_CTRL_IRQ_EN
    axi_write(5'h0c, 32'h1, 4'hf, 0, 0);
    ch_ovf = 2'b01; idle(1); ch_ovf = '0;
    idle(2);
    check("irq_high_literal", 64'(irq), 64'(1));
    axi_write(5'h08, 32'h1, 4'hf, 0, 0);
    idle(1);
    check("irq_low_literal", 64'(irq), 64'(0));
`else
    axi_read(5'h0c, 0, d, r);
    check("irq_mask_absent_literal", 64'({r, d}), 64'({2'b10, 32'h0}));
`endif

    fork
      axi_write(5'h04, 32'h2, 4'hf, 0, 0);
      axi_read(5'h04, 0, d, r);
    join
    check("same_cycle_old_literal", 64'(d), 64'(1));

    for (int k = 0; k < 150; k++) begin
      ch_ovf = NCH'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 3), d, r);
      if ($urandom_range(0, 3) == 0) begin
        ch_ovf = '0;
        idle($urandom_range(1, 20));
      end
    end
    ch_ovf = '0;

    axi_write(5'h04, 32'h3, 4'hf, 0, 0);
    axi_write(5'h00, 32'h1, 4'hf, 0, 0);
    idle(20);
    check("pre_abort_data_en_literal", 64'(data_en), 64'(2'b11));
    awaddr = 5'h00; wdata = 32'h2; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h10; arvalid = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_awready", 64'(awready), 64'(0));
    check("abort_arready", 64'(arready), 64'(0));
    check("abort_bvalid", 64'(bvalid), 64'(0));
    check("abort_data_en", 64'(data_en), 64'(0));
    check("abort_ddr_reset", 64'(ddr_reset), 64'(1));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    axi_read(5'h10, 0, d, r);
    axi_read(5'h04, 0, d, r);
    check("post_abort_ch_en_literal", 64'(d), 64'(0));
    idle(2);
    check("queues_drained", 64'(exp_q.size() + exp_b_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
